axis_alex_rx: RTL

AXIS_ALEX_RX -- requirements
Module: axis_alex_rx

---
 rtl/axis_alex_rx_pkg.sv | 18 +
 rtl/axis_alex_rx_if.sv | 11 +
 rtl/axis_alex_rx_sync.sv | 44 ++++
 rtl/axis_alex_rx.sv | 108 ++++++++++
 4 files changed

// File: rtl/axis_alex_rx_pkg.sv
// Shared constants, state encoding and saturation helper for the alex serial receiver.
package axis_alex_rx_pkg;

  localparam int FRAME_W = 16;
  localparam int LOAD_W  = 2;

  localparam logic [7:0] SAT_MAX = 8'd255;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_SHIFT     = 2'd1;
  localparam state_t ST_LOAD_WAIT = 2'd2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SAT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axis_alex_rx_if.sv
// AXI-Stream output bundle of the alex receiver.
// Handshake: a word transfers on any aclk edge where tvalid && tready; once tvalid
// is high, tdata holds stable until that transfer.
interface axis_alex_rx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_alex_rx_sync.sv
// Input capture and rising-edge detection for the 4-bit alex link.
// AXIS_ALEX_RX_SYNC_EN adds a 2-flop synchronizer ahead of the capture register.
module alex_rx_sync (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [3:0] din,
  output logic [3:0] lvl,
  output logic [3:0] rise
);

  logic [3:0] lvl_q;
  logic [3:0] prev_q;

`ifdef AXIS_ALEX_RX_SYNC_EN
  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      meta_q <= '0;
      sync_q <= '0;
      lvl_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      lvl_q  <= sync_q;
    end
  end
`else
  always_ff @(posedge aclk) begin
    if (!aresetn) lvl_q <= '0;
    else          lvl_q <= din;
  end
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) prev_q <= '0;
    else          prev_q <= lvl_q;
  end

  assign lvl  = lvl_q;
  assign rise = lvl_q & ~prev_q;

endmodule

// File: rtl/axis_alex_rx.sv
// Alex serial-link receiver: shifts sclk/sdata frames, emits them on AXI-Stream on a load strobe.
// Optional AXIS_ALEX_RX_SYNC_EN inserts a 2-flop input synchronizer.
module axis_alex_rx
  import axis_alex_rx_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [3:0]            alex_data,
  axis_alex_rx_if.master        m_axis,
  output logic [7:0]            err_count,
  output logic [7:0]            ovf_count,
  output state_t                dbg_state
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [3:0]         lvl;
  logic [3:0]         rise;
  logic               load_prev_q;
  logic               load_any;
  logic               load_edge;
  logic               sclk_rise;
  logic               sdata;
  logic               frame_ok;
  logic               unused_sync_bits;

  state_t             state_q;
  logic [FRAME_W-1:0] shreg_q;
  logic [4:0]         bit_cnt_q;
  logic [15:0]        tmo_q;

  alex_rx_sync u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .din     (alex_data),
    .lvl     (lvl),
    .rise    (rise)
  );

  // Edge of the OR of both strobes: some strobe rose and neither was high before.
  assign load_any         = |lvl[3:2];
  assign load_edge        = (|rise[3:2]) & ~load_prev_q;
  assign sclk_rise        = rise[0];
  assign sdata            = lvl[1];
  assign frame_ok         = load_edge && (bit_cnt_q == 5'(FRAME_W));
  assign unused_sync_bits = &{1'b0, lvl[0], rise[1]};

  always_ff @(posedge aclk) begin
    if (!aresetn) load_prev_q <= 1'b0;
    else          load_prev_q <= load_any;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      err_count <= '0;
    end else if (load_edge) begin
      if (bit_cnt_q != 5'(FRAME_W)) err_count <= sat_inc(err_count);
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      state_q   <= ST_LOAD_WAIT;
    end else if (state_q == ST_LOAD_WAIT) begin
      if (!load_any) state_q <= ST_IDLE;
    end else if (sclk_rise) begin
      shreg_q   <= {sdata, shreg_q[FRAME_W-1:1]};
      bit_cnt_q <= (bit_cnt_q == 5'd31) ? bit_cnt_q : bit_cnt_q + 5'd1;
      tmo_q     <= '0;
      state_q   <= ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      // A stalled partial frame is dropped so the next strobe starts clean.
      if (tmo_q == TMO_LAST) begin
        err_count <= sat_inc(err_count);
        shreg_q   <= '0;
        bit_cnt_q <= '0;
        tmo_q     <= '0;
        state_q   <= ST_IDLE;
      end else begin
        tmo_q <= tmo_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      ovf_count     <= '0;
    end else if (frame_ok) begin
      if (!m_axis.tvalid || m_axis.tready) begin
        m_axis.tdata  <= {14'b0, lvl[3:2], shreg_q};
        m_axis.tvalid <= 1'b1;
      end else begin
        ovf_count <= sat_inc(ovf_count);
      end
    end else if (m_axis.tvalid && m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

  assign dbg_state = state_q;

endmodule
